// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential ALU: command encoding, FSM states,
// iteration modes and error-flag bit positions.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    MUL = 4'd3,
    DIV = 4'd4,
    MOD = 4'd5
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    IT_MUL,
    IT_DIV,
    IT_MOD
  } iter_mode_e;

  localparam int ERR_DBZ_BIT = 1;
  localparam int ERR_OVF_BIT = 0;

endpackage

// File: rtl/seq_alu_iter.sv
// Shared shift register for MUL/DIV/MOD: shift-add multiply or restoring divide,
// one operand bit per step. nxt_result is the value the register holds after this step.
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  iter_mode_e         mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] nxt_result
);

  // hi: partial product / partial remainder; lo: multiplier bits / quotient bits
  logic [WIDTH:0]   hi, hi_n, sum, rs, diff;
  logic [WIDTH-1:0] lo, lo_n, dvs;

  always_comb begin
    sum  = hi + (lo[0] ? {1'b0, dvs} : '0);
    rs   = {hi[WIDTH-1:0], lo[WIDTH-1]};
    diff = rs - {1'b0, dvs};
    hi_n = hi;
    lo_n = lo;
    if (mode == IT_MUL) begin
      hi_n = {1'b0, sum[WIDTH:1]};
      lo_n = {sum[0], lo[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      hi_n = diff;
      lo_n = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_n = rs;
      lo_n = {lo[WIDTH-2:0], 1'b0};
    end
    case (mode)
      IT_MUL:  nxt_result = {hi_n[WIDTH-1:0], lo_n};
      IT_DIV:  nxt_result = {{WIDTH{1'b0}}, lo_n};
      default: nxt_result = {{WIDTH{1'b0}}, hi_n[WIDTH-1:0]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi  <= '0;
      lo  <= '0;
      dvs <= '0;
    end else if (load) begin
      hi  <= '0;
      lo  <= a;
      dvs <= b;
    end else if (step) begin
      hi  <= hi_n;
      lo  <= lo_n;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes: ADD/SUB in one cycle, MUL/DIV/MOD iterative.
// Optional SEQ_ALU_PERF_EN adds perf_ops/perf_cycles counters.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CMD_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [CMD_W-1:0]   in_cmd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic [1:0]         out_error
`ifdef SEQ_ALU_PERF_EN
  ,
  output logic [31:0]        perf_ops,
  output logic [31:0]        perf_cycles
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [CMD_W-1:0]   cmd_q;
  logic               accept, iterative;
  iter_mode_e         mode;
  logic [2*WIDTH-1:0] iter_res;
  logic [2*WIDTH+1:0] quick;

  // Single-cycle ops packed as {error, result}; SUB is A + ~B + 1.
  function automatic logic [2*WIDTH+1:0] quick_op(input logic [CMD_W-1:0] cmd,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [2*WIDTH+1:0] r;
    logic [WIDTH:0]     s;
    logic [WIDTH-1:0]   bo;
    logic               sub;
    r   = '0;
    sub = (cmd == CMD_W'(SUB));
    bo  = sub ? ~b : b;
    s   = {1'b0, a} + {1'b0, bo} + {{WIDTH{1'b0}}, sub};
    if (cmd == CMD_W'(ADD) || sub) begin
      r[WIDTH-1:0] = s[WIDTH-1:0];
      r[2*WIDTH+ERR_OVF_BIT] = s[WIDTH] ^ (a[WIDTH-1] ^ bo[WIDTH-1] ^ s[WIDTH-1]);
    end else if (cmd == CMD_W'(DIV) || cmd == CMD_W'(MOD)) begin
      r[2*WIDTH+ERR_DBZ_BIT] = 1'b1;
    end
    return r;
  endfunction

  assign quick     = quick_op(in_cmd, in_a, in_b);
  assign iterative = (in_cmd == CMD_W'(MUL)) ||
                     ((in_cmd == CMD_W'(DIV) || in_cmd == CMD_W'(MOD)) && in_b != '0);
  assign accept    = in_valid && in_ready;
  assign mode      = (cmd_q == CMD_W'(MUL)) ? IT_MUL :
                     (cmd_q == CMD_W'(DIV)) ? IT_DIV : IT_MOD;

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = iterative ? CALC : DONE;
      end
      CALC:    if (cnt == '0) state_n = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      cmd_q      <= '0;
      out_result <= '0;
      out_error  <= '0;
    end else if (accept) begin
      cmd_q <= in_cmd;
      cnt   <= CNT_W'(WIDTH - 1);
      if (iterative) {out_error, out_result} <= '0;
      else           {out_error, out_result} <= quick;
    end else if (state == CALC) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == '0) out_result <= iter_res;
    end
  end

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .step       (state == CALC),
    .mode       (mode),
    .a          (in_a),
    .b          (in_b),
    .nxt_result (iter_res)
  );

`ifdef SEQ_ALU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops    <= '0;
      perf_cycles <= '0;
    end else begin
      if (out_valid && out_ready) perf_ops <= perf_ops + 32'd1;
      if (state != IDLE)          perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=16): directed plan values plus random ops
// against an arithmetic reference model; latency, back-pressure and mid-op reset.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [3:0]  in_cmd = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [1:0]  out_error;
`ifdef SEQ_ALU_PERF_EN
  logic [31:0] perf_ops, perf_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int ops_exp = 0;
  int cyc_exp = 0;
  int xfers_exp = 0;
  int xfers = 0;

  seq_alu #(.WIDTH(16), .CMD_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_cmd     (in_cmd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_error  (out_error)
`ifdef SEQ_ALU_PERF_EN
    ,
    .perf_ops    (perf_ops),
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && out_valid && out_ready) xfers <= xfers + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input logic [3:0] cmd, input logic [15:0] a, input logic [15:0] b,
                                output logic [31:0] r, output logic [1:0] e, output int lat);
    int sa, sb, s;
    sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
    sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
    r = '0; e = '0; lat = 1;
    case (cmd)
      4'd1: begin
        r = 32'((int'(a) + int'(b)) % 65536);
        s = sa + sb;
        e[0] = (s > 32767) || (s < -32768);
      end
      4'd2: begin
        r = 32'((int'(a) - int'(b) + 65536) % 65536);
        s = sa - sb;
        e[0] = (s > 32767) || (s < -32768);
      end
      4'd3: begin
        r = 32'(longint'(a) * longint'(b));
        lat = 17;
      end
      4'd4, 4'd5: begin
        if (b == 0) e = 2'b10;
        else begin
          r = (cmd == 4'd4) ? 32'(a / b) : 32'(a % b);
          lat = 17;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic do_op(input logic [3:0] cmd, input logic [15:0] a, input logic [15:0] b,
                       input int stall, input string tag);
    logic [31:0] er;
    logic [1:0]  ee;
    int          el, lat;
    bit          seen;
    model(cmd, a, b, er, ee, el);
    @(negedge clk);
    in_valid = 1'b1; in_cmd = cmd; in_a = a; in_b = b;
    out_ready = (stall == 0);
    check({tag, "/in_ready_idle"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    check({tag, "/latency"}, 64'(lat), 64'(el));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "/hold_result"}, 64'(out_result), 64'(er));
      check({tag, "/hold_busy"}, 64'({in_ready, out_valid}), 64'b01);
    end
    check({tag, "/result"}, 64'(out_result), 64'(er));
    check({tag, "/error"}, 64'(out_error), 64'(ee));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "/after_hs"}, 64'({in_ready, out_valid}), 64'b10);
    ops_exp++;
    xfers_exp++;
    cyc_exp += el + stall;
  endtask

  initial begin
    logic [3:0]  rc;
    logic [15:0] ra, rb;
    repeat (3) @(posedge clk);
    #1;
    check("reset/in_ready", 64'(in_ready), 64'd1);
    check("reset/out_valid", 64'(out_valid), 64'd0);
    check("reset/out_result", 64'(out_result), 64'd0);
    check("reset/out_error", 64'(out_error), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int c = 1; c <= 5; c++) do_op(4'(c), 16'd249, 16'd69, 0, "plan_small");
    for (int c = 1; c <= 5; c++) do_op(4'(c), 16'd32000, 16'd8193, 0, "plan_large");
    do_op(4'd4, 16'd500, 16'd0, 0, "div_by_zero");
    do_op(4'd5, 16'd500, 16'd0, 0, "mod_by_zero");
    do_op(4'd3, 16'd300, 16'd400, 10, "backpressure_mul");
    #20;
    check("backpressure/one_xfer", 64'(xfers), 64'(xfers_exp));
    do_op(4'd9, 16'd1234, 16'd77, 0, "reserved9");
    do_op(4'd0, 16'd5, 16'd6, 0, "nop");
    do_op(4'd3, 16'd1234, 16'd0, 0, "mul_by_zero");
    do_op(4'd3, 16'hFFFF, 16'hFFFF, 1, "mul_max");
    do_op(4'd2, 16'h8000, 16'd1, 0, "sub_ovf");

    for (int n = 0; n < 40; n++) begin
      rc = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) rc = 4'($urandom_range(1, 5));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
      do_op(rc, ra, rb, $urandom_range(0, 3), "random");
    end

`ifdef SEQ_ALU_PERF_EN
    check("perf/ops", 64'(perf_ops), 64'(ops_exp));
    check("perf/cycles", 64'(perf_cycles), 64'(cyc_exp));
`endif
    check("xfers/total", 64'(xfers), 64'(xfers_exp));

    // Abort a DIV in the middle of its iterations.
    @(negedge clk);
    in_valid = 1'b1; in_cmd = 4'd4; in_a = 16'd65535; in_b = 16'd7; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset/in_ready", 64'(in_ready), 64'd1);
    check("midreset/out_valid", 64'(out_valid), 64'd0);
    check("midreset/out_result", 64'(out_result), 64'd0);
    check("midreset/out_error", 64'(out_error), 64'd0);
`ifdef SEQ_ALU_PERF_EN
    check("midreset/perf_ops", 64'(perf_ops), 64'd0);
`endif
    ops_exp = 0;
    cyc_exp = 0;
    @(negedge clk) rst_n = 1'b1;
    do_op(4'd1, 16'd1, 16'd1, 0, "post_reset_add");
    #20;
    check("post_reset/xfers", 64'(xfers), 64'(xfers_exp));
`ifdef SEQ_ALU_PERF_EN
    check("post_reset/perf_ops", 64'(perf_ops), 64'(ops_exp));
    check("post_reset/perf_cycles", 64'(perf_cycles), 64'(cyc_exp));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
